// File: rtl/bcd2binary_reverse_dabble.sv
// Sequential packed-BCD to binary converter (reverse double dabble), one bit per cycle.
// Define BCD2BIN_CHECK_EN to flag digits > 9 early with err instead of converting them.
module bcd2binary_reverse_dabble #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    binary_out,
  output logic                err,
  output logic                ovf
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(BIN_W - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e              state_q, state_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BIN_W-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, done_q;

  logic [BcdW+BIN_W-1:0] shifted;
  logic [BcdW-1:0]       adj_bcd;
  logic [BIN_W-1:0]      sh_bin;

  // One reverse-dabble step: shift the whole chain right, then pull digits >= 8 back by 3.
  always_comb begin
    shifted = {bcd_q, bin_q} >> 1;
    sh_bin  = shifted[BIN_W-1:0];
    adj_bcd = shifted[BcdW+BIN_W-1:BIN_W];
    for (int i = 0; i < DIGITS; i++) begin
      if (adj_bcd[4*i +: 4] >= 4'd8) begin
        adj_bcd[4*i +: 4] = adj_bcd[4*i +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic err_q, err_d;
  logic bcd_bad;

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
`ifdef BCD2BIN_CHECK_EN
    err_d    = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          bcd_d = bcd_in;
          bin_d = '0;
          cnt_d = '0;
`ifdef BCD2BIN_CHECK_EN
          if (bcd_bad) begin
            state_d  = StDone;
            result_d = '0;
            err_d    = 1'b1;
            ovf_d    = 1'b0;
          end else begin
            state_d = StConv;
            err_d   = 1'b0;
          end
`else
          state_d = StConv;
`endif
        end
      end
      StConv: begin
        bcd_d = adj_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastIter) begin
          // Anything left in the BCD side is value >> BIN_W, i.e. an overflow.
          result_d = sh_bin;
          ovf_d    = (adj_bcd != '0);
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
    end
  end

`ifdef BCD2BIN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign binary_out = result_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_bcd2binary_reverse_dabble.sv
// Self-checking bench: directed and random operands against an arithmetic BCD value model.
module tb_bcd2binary_reverse_dabble;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start8;
  logic [11:0] bcd_in, bcd8;
  logic        busy, done, err, ovf;
  logic [9:0]  binary_out;
  logic        busy8, done8, err8, ovf8;
  logic [7:0]  bin8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd2binary_reverse_dabble #(.DIGITS(3), .BIN_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bcd_in     (bcd_in),
    .busy       (busy),
    .done       (done),
    .binary_out (binary_out),
    .err        (err),
    .ovf        (ovf)
  );

  bcd2binary_reverse_dabble #(.DIGITS(3), .BIN_W(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start8),
    .bcd_in     (bcd8),
    .busy       (busy8),
    .done       (done8),
    .binary_out (bin8),
    .err        (err8),
    .ovf        (ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned bcd_value(input logic [11:0] b);
    return 32'(b[11:8]) * 100 + 32'(b[7:4]) * 10 + 32'(b[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int unsigned n);
    logic [11:0] b;
    b[11:8] = 4'((n / 100) % 10);
    b[7:4]  = 4'((n / 10) % 10);
    b[3:0]  = 4'(n % 10);
    return b;
  endfunction

  // One conversion on the 10-bit DUT. bcd_in is scrambled right after acceptance.
  // lat counts negedges after the accepting edge up to the first one with done high.
  task automatic run10(input logic [11:0] v, output int lat, output logic done_after,
                       output logic busy_after);
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'h999;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic run8(input logic [11:0] v, output int lat);
    @(negedge clk);
    bcd8   = v;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    bcd8   = 12'h000;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done8) lat = -1;
    @(negedge clk);
  endtask

  initial begin
    int          lat;
    logic        d_after, b_after;
    int unsigned val;
    logic [11:0] v;
    int          pulses;
    int          last_k;
    int          seen_done;

    rst = 1'b1; start = 1'b0; start8 = 1'b0; bcd_in = '0; bcd8 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bin", 32'(binary_out), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 255: latency and busy framing
    @(negedge clk);
    bcd_in = 12'h255;
    start  = 1'b1;
    chk("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("lat_255", 32'(lat), 32'd11);
    chk("bin_255", 32'(binary_out), 32'd255);
    chk("ovf_255", 32'(ovf), 32'd0);
    chk("err_255", 32'(err), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);

    // loopback sweep: binary n -> BCD -> DUT -> n
    for (int n = 0; n < 1000; n++) begin
      run10(to_bcd(n), lat, d_after, b_after);
      chk("sweep", {lat[7:0], 3'b0, ovf, err, d_after, binary_out, 8'(n % 256)},
          {8'd11, 3'b0, 1'b0, 1'b0, 1'b0, 10'(n), 8'(n % 256)});
    end

    // invalid digit
    run10(12'h1A3, lat, d_after, b_after);
`ifdef BCD2BIN_CHECK_EN
    chk("inv_lat", 32'(lat), 32'd1);
    chk("inv_err", 32'(err), 32'd1);
    chk("inv_bin", 32'(binary_out), 32'd0);
    chk("inv_ovf", 32'(ovf), 32'd0);
    for (int r = 0; r < 10; r++) begin
      v = to_bcd($urandom_range(0, 999));
      v[4*(r%3) +: 4] = 4'($urandom_range(10, 15));
      run10(v, lat, d_after, b_after);
      chk("inv_rand", {lat[15:0], 15'd0, err}, {16'd1, 15'd0, 1'b1});
    end
`else
    chk("inv_lat", 32'(lat), 32'd11);
    chk("inv_err", 32'(err), 32'd0);
`endif
    chk("inv_done_after", 32'(d_after), 32'd0);

    // 8-bit result width: overflow and wrap
    run8(12'h300, lat);
    chk("ovf8_lat", 32'(lat), 32'd9);
    chk("ovf8_flag", 32'(ovf8), 32'd1);
    chk("ovf8_bin", 32'(bin8), 32'd44);
    run8(12'h255, lat);
    chk("w8_flag", 32'(ovf8), 32'd0);
    chk("w8_bin", 32'(bin8), 32'd255);
    for (int r = 0; r < 40; r++) begin
      val = $urandom_range(0, 999);
      run8(to_bcd(val), lat);
      chk("rand8", {lat[15:0], 7'd0, ovf8, bin8},
          {16'd9, 7'd0, (val >= 256), 8'(val % 256)});
    end
    for (int r = 0; r < 20; r++) begin
      val = $urandom_range(0, 999);
      run10(to_bcd(val), lat, d_after, b_after);
      chk("rand10", 32'(binary_out), val);
      chk("rand10_bcdval", bcd_value(to_bcd(val)), 32'(binary_out));
    end

    // held start: done every 12 cycles, always 42
    @(negedge clk);
    bcd_in = 12'h042;
    start  = 1'b1;
    pulses = 0;
    last_k = -1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (done) begin
        chk("held_bin", 32'(binary_out), 32'd42);
        if (last_k < 0) chk("held_first", 32'(k), 32'd11);
        else chk("held_period", 32'(k - last_k), 32'd12);
        last_k = k;
        pulses++;
      end
    end
    start = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd3);
    repeat (2) @(negedge clk);
    chk("held_idle", 32'(busy), 32'd0);

    // async reset mid-conversion of 999
    @(negedge clk);
    bcd_in = 12'h999;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bin", 32'(binary_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("rst_no_done", 32'(seen_done), 32'd0);
    run10(12'h007, lat, d_after, b_after);
    chk("post_rst_lat", 32'(lat), 32'd11);
    chk("post_rst_bin", 32'(binary_out), 32'd7);
    chk("post_rst_busy", 32'(b_after), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
